id_exe_ctrl: RTL and testbench
==============================

Name: id_exe_ctrl

Overview:
- Control pipeline register between ID and EXE, plus the hazard/forwarding scheduler for the EXE datapath.
- Latches decoded ID controls into the EXE control set: ealuc, ealuimm, eshift, em2reg, ewmem, ewreg, ern.
- Produces ID-stage operand forwarding selects and detects load-use hazards, stalling PC/IF-ID and injecting a bubble into EXE.
- Counts stall cycles for performance debug.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- daluc  in  3  decoded ALU control.
- daluimm  in  1  ALU b-input selects immediate.
- dshift  in  1  ALU a-input selects shift amount.
- dm2reg  in  1  instruction is a load.
- dwmem  in  1  instruction is a store.
- dwreg  in  1  instruction writes the register file.
- drn  in  5  destination register of the ID instruction.
- drs  in  5  rs field of the ID instruction.
- drt  in  5  rt field of the ID instruction.
- duse_rs  in  1  ID instruction reads rs.
- duse_rt  in  1  ID instruction reads rt (ALU operand or store data).
- flush  in  1  squash the ID instruction (taken branch/jump resolved).
- mrn  in  5  MEM-stage destination register.
- mwreg  in  1  MEM-stage register write.
- mm2reg  in  1  MEM-stage instruction is a load.
- ealuc  out  3  registered EXE ALU control.
- ealuimm  out  1  registered EXE b-input select.
- eshift  out  1  registered EXE a-input select.
- em2reg  out  1  registered EXE load flag.
- ewmem  out  1  registered EXE store flag.
- ewreg  out  1  registered EXE register-write flag.
- ern  out  5  registered EXE destination register.
- fwda  out  2  rs operand select: 0 regfile, 1 ealu, 2 MEM alu result, 3 MEM load data.
- fwdb  out  2  rt operand select, same encoding as fwda.
- wpcir  out  1  PC and IF/ID write enable; 0 = stall.
- stall_cnt  out  CNT_W  number of stall cycles since reset.

Behaviour:
- Reset (rst=1 at a rising edge): ealuc=0, ealuimm=0, eshift=0, em2reg=0, ewmem=0, ewreg=0, ern=0, stall_cnt=0. rst has priority over flush and stall.
- Hazard term (combinational):
  - ld_haz = ewreg & em2reg & (ern != 0) & ((duse_rs & ern == drs) | (duse_rt & ern == drt)).
  - wpcir = ~ld_haz.
- Forwarding for fwda (combinational, first match wins; fwdb is identical using drt/duse_rt):
  - (a) duse_rs & ewreg & ~em2reg & ern != 0 & ern == drs -> 1.
  - (b) duse_rs & mwreg & mrn != 0 & mrn == drs -> 2 if ~mm2reg, else 3.
  - (c) otherwise -> 0.
  - EXE has priority over MEM when both match.
  - Register 0 is never forwarded.
  - A load in EXE never produces select 1; ld_haz covers that case.
- EXE control register update each rising edge when rst=0:
  - If ld_haz or flush: load a bubble. All e* outputs = 0, including ern = 0.
  - Otherwise: e* <= d* (ealuc<=daluc, ..., ern<=drn).
  - flush together with ld_haz: bubble; wpcir is still driven by ld_haz alone.
- Latency:
  - Controls appear on e* one cycle after being presented on d*.
  - A load-use hazard costs exactly one stall cycle. On the next cycle the load is in MEM, so the select resolves to 3 and wpcir returns to 1.
- stall_cnt increments by 1 on every edge with ld_haz=1. It saturates at all-ones and never wraps.
- wpcir, fwda and fwdb have no registered state of their own. They are valid in the same cycle as the d*/m* inputs.

Decomposition:
- Shared package holds:
  - FWD_REG=2'd0, FWD_EALU=2'd1, FWD_MALU=2'd2, FWD_MMO=2'd3.
  - ALU control width constant (3).
  - Register-index width constant (5).
- One natural sub-module, fwd_sel: the combinational per-operand priority selector. It is instantiated twice, once for rs and once for rt.
- The hazard logic, the EXE control register and the counter stay in the top module.

Test Plan:
- Reset: assert rst with d* non-zero -> after the edge all e*=0, stall_cnt=0, wpcir=1, fwda=fwdb=0.
- EXE forward:
  - Stimulus: add $3 in EXE (ewreg=1, em2reg=0, ern=3); ID has drs=3, duse_rs=1; MEM also has mrn=3, mwreg=1.
  - Required: fwda=1 (EXE priority), wpcir=1.
- Load-use:
  - Stimulus: lw $5 in EXE (em2reg=1, ern=5); ID has drt=5, duse_rt=1.
  - Required: wpcir=0. Next edge: ewreg=0, ern=0, stall_cnt=1.
  - Following cycle with mrn=5, mwreg=1, mm2reg=1: fwdb=3, wpcir=1.
- Register zero: ern=0 with ewreg=1 and drs=0, duse_rs=1 -> fwda=0, wpcir=1, even when em2reg=1.
- Flush:
  - Stimulus: flush=1 with dwmem=1, dwreg=1, drn=7.
  - Required: next edge ewmem=0, ewreg=0, ern=0; stall_cnt unchanged.
- Counter saturation: CNT_W=4, hold ld_haz for 20 cycles -> stall_cnt stays at 15 and never wraps to 0.

Source files
------------

// File: rtl/id_exe_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_exe_ctrl_pkg : shared types for the ID/EXE control slice  rev 1.0 |
// +--------------------------------------------------------------------+
package id_exe_ctrl_pkg;

   localparam int ALUC_W = 3;
   localparam int REG_W  = 5;

   typedef enum logic [1:0] {
      FWD_REG  = 2'd0,
      FWD_EALU = 2'd1,
      FWD_MALU = 2'd2,
      FWD_MMO  = 2'd3
   } fwd_e;

   typedef struct packed {
      logic [ALUC_W-1:0] aluc;
      logic              aluimm;
      logic              shift;
      logic              m2reg;
      logic              wmem;
      logic              wreg;
      logic [REG_W-1:0]  rn;
   } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/id_exe_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_exe_ctrl_if : ID/MEM inputs and EXE/hazard outputs      rev 1.0 |
// +--------------------------------------------------------------------+
interface id_exe_ctrl_if #(parameter int CNT_W = 32);

   logic [2:0]       daluc;
   logic             daluimm;
   logic             dshift;
   logic             dm2reg;
   logic             dwmem;
   logic             dwreg;
   logic [4:0]       drn;
   logic [4:0]       drs;
   logic [4:0]       drt;
   logic             duse_rs;
   logic             duse_rt;
   logic             flush;
   logic [4:0]       mrn;
   logic             mwreg;
   logic             mm2reg;

   logic [2:0]       ealuc;
   logic             ealuimm;
   logic             eshift;
   logic             em2reg;
   logic             ewmem;
   logic             ewreg;
   logic [4:0]       ern;
   logic [1:0]       fwda;
   logic [1:0]       fwdb;
   logic             wpcir;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output daluc, daluimm, dshift, dm2reg, dwmem, dwreg, drn, drs, drt,
             duse_rs, duse_rt, flush, mrn, mwreg, mm2reg,
      input  ealuc, ealuimm, eshift, em2reg, ewmem, ewreg, ern,
             fwda, fwdb, wpcir, stall_cnt
   );

   modport slave (
      input  daluc, daluimm, dshift, dm2reg, dwmem, dwreg, drn, drs, drt,
             duse_rs, duse_rt, flush, mrn, mwreg, mm2reg,
      output ealuc, ealuimm, eshift, em2reg, ewmem, ewreg, ern,
             fwda, fwdb, wpcir, stall_cnt
   );

endinterface
`default_nettype wire

// File: rtl/id_exe_ctrl_fwd_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_exe_ctrl_fwd_sel : per-operand forwarding priority mux  rev 1.0 |
// +--------------------------------------------------------------------+
module id_exe_ctrl_fwd_sel
   import id_exe_ctrl_pkg::*;
(
   input  logic             i_use,
   input  logic [REG_W-1:0] i_reg,
   input  logic             i_ewreg,
   input  logic             i_em2reg,
   input  logic [REG_W-1:0] i_ern,
   input  logic             i_mwreg,
   input  logic             i_mm2reg,
   input  logic [REG_W-1:0] i_mrn,
   output fwd_e             o_sel
);

   // A load in EXE is deliberately skipped here; the stall covers it.
   always_comb begin
      o_sel = FWD_REG;
      if (i_use && i_ewreg && !i_em2reg && (i_ern != '0) && (i_ern == i_reg)) begin
         o_sel = FWD_EALU;
      end else if (i_use && i_mwreg && (i_mrn != '0) && (i_mrn == i_reg)) begin
         o_sel = i_mm2reg ? FWD_MMO : FWD_MALU;
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_exe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_exe_ctrl : ID/EXE control register, load-use stall, fwd  rev 1.0 |
// +--------------------------------------------------------------------+
module id_exe_ctrl
   import id_exe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   id_exe_ctrl_if.slave bus
);

   ctrl_t            ctrl_q, ctrl_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             w_ld_haz;
   fwd_e             w_fwda, w_fwdb;

   assign w_ld_haz = ctrl_q.wreg && ctrl_q.m2reg && (ctrl_q.rn != '0) &&
                     ((bus.duse_rs && (ctrl_q.rn == bus.drs)) ||
                      (bus.duse_rt && (ctrl_q.rn == bus.drt)));

   id_exe_ctrl_fwd_sel u_fwd_rs (
      .i_use    (bus.duse_rs),
      .i_reg    (bus.drs),
      .i_ewreg  (ctrl_q.wreg),
      .i_em2reg (ctrl_q.m2reg),
      .i_ern    (ctrl_q.rn),
      .i_mwreg  (bus.mwreg),
      .i_mm2reg (bus.mm2reg),
      .i_mrn    (bus.mrn),
      .o_sel    (w_fwda)
   );

   id_exe_ctrl_fwd_sel u_fwd_rt (
      .i_use    (bus.duse_rt),
      .i_reg    (bus.drt),
      .i_ewreg  (ctrl_q.wreg),
      .i_em2reg (ctrl_q.m2reg),
      .i_ern    (ctrl_q.rn),
      .i_mwreg  (bus.mwreg),
      .i_mm2reg (bus.mm2reg),
      .i_mrn    (bus.mrn),
      .o_sel    (w_fwdb)
   );

   // A stalled or squashed instruction enters EXE as an all-zero bubble.
   always_comb begin
      ctrl_d = '0;
      if (!(w_ld_haz || bus.flush)) begin
         ctrl_d.aluc   = bus.daluc;
         ctrl_d.aluimm = bus.daluimm;
         ctrl_d.shift  = bus.dshift;
         ctrl_d.m2reg  = bus.dm2reg;
         ctrl_d.wmem   = bus.dwmem;
         ctrl_d.wreg   = bus.dwreg;
         ctrl_d.rn     = bus.drn;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (w_ld_haz && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.ealuc     = ctrl_q.aluc;
   assign bus.ealuimm   = ctrl_q.aluimm;
   assign bus.eshift    = ctrl_q.shift;
   assign bus.em2reg    = ctrl_q.m2reg;
   assign bus.ewmem     = ctrl_q.wmem;
   assign bus.ewreg     = ctrl_q.wreg;
   assign bus.ern       = ctrl_q.rn;
   assign bus.fwda      = w_fwda;
   assign bus.fwdb      = w_fwdb;
   assign bus.wpcir     = !w_ld_haz;
   assign bus.stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_id_exe_ctrl : scoreboard bench with a behavioural model  rev 1.0 |
// +--------------------------------------------------------------------+
module tb_id_exe_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   typedef struct packed {
      logic [2:0] aluc;
      logic       aluimm;
      logic       shift;
      logic       m2reg;
      logic       wmem;
      logic       wreg;
      logic [4:0] rn;
   } exe_t;

   typedef struct {
      logic       rst;
      exe_t       d;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic       flush;
      logic [4:0] mrn;
      logic       mwreg;
      logic       mm2reg;
   } stim_t;

   typedef struct {
      int   fwda;
      int   fwdb;
      int   wpcir;
      exe_t e;
      int   cnt;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   item_t sb_q[$];
   exe_t  m_e;
   int    m_cnt;

   id_exe_ctrl_if #(.CNT_W(CNT_W)) bus ();

   id_exe_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an instruction reading register r gets the youngest older
   // non-load producer from EXE, otherwise the MEM-stage value; r0 never.
   function automatic int model_fwd(input logic use_r, input logic [4:0] r, input stim_t s);
      if (!use_r || r == 0) return 0;
      if (m_e.wreg && !m_e.m2reg && m_e.rn == r) return 1;
      if (s.mwreg && s.mrn == r) return s.mm2reg ? 3 : 2;
      return 0;
   endfunction

   function automatic bit model_haz(input stim_t s);
      bit reads_rs, reads_rt;
      if (!(m_e.wreg && m_e.m2reg) || m_e.rn == 0) return 0;
      reads_rs = s.use_rs && (s.rs == m_e.rn);
      reads_rt = s.use_rt && (s.rt == m_e.rn);
      return reads_rs || reads_rt;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 1'b0, d: '0, rs: 5'd0, rt: 5'd0, use_rs: 1'b0, use_rt: 1'b0,
            flush: 1'b0, mrn: 5'd0, mwreg: 1'b0, mm2reg: 1'b0};
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s = idle();
      s.d.aluc   = 3'($urandom_range(0, 7));
      s.d.aluimm = 1'($urandom_range(0, 1));
      s.d.shift  = 1'($urandom_range(0, 1));
      s.d.m2reg  = 1'($urandom_range(0, 1));
      s.d.wmem   = 1'($urandom_range(0, 1));
      s.d.wreg   = 1'($urandom_range(0, 1));
      s.d.rn     = 5'($urandom_range(0, 3));
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.use_rs   = 1'($urandom_range(0, 1));
      s.use_rt   = 1'($urandom_range(0, 1));
      s.flush    = ($urandom_range(0, 7) == 0);
      s.mrn      = 5'($urandom_range(0, 3));
      s.mwreg    = 1'($urandom_range(0, 1));
      s.mm2reg   = 1'($urandom_range(0, 1));
      return s;
   endfunction

   // Drive one cycle, queue its expectation, advance the model past the edge.
   task automatic step(input stim_t s);
      item_t it;
      bit    haz;
      @(posedge clk);
      #2;
      rst         = s.rst;
      bus.daluc   = s.d.aluc;
      bus.daluimm = s.d.aluimm;
      bus.dshift  = s.d.shift;
      bus.dm2reg  = s.d.m2reg;
      bus.dwmem   = s.d.wmem;
      bus.dwreg   = s.d.wreg;
      bus.drn     = s.d.rn;
      bus.drs     = s.rs;
      bus.drt     = s.rt;
      bus.duse_rs = s.use_rs;
      bus.duse_rt = s.use_rt;
      bus.flush   = s.flush;
      bus.mrn     = s.mrn;
      bus.mwreg   = s.mwreg;
      bus.mm2reg  = s.mm2reg;
      haz      = model_haz(s);
      it.fwda  = model_fwd(s.use_rs, s.rs, s);
      it.fwdb  = model_fwd(s.use_rt, s.rt, s);
      it.wpcir = haz ? 0 : 1;
      it.e     = m_e;
      it.cnt   = m_cnt;
      sb_q.push_back(it);
      if (s.rst) begin
         m_e   = '0;
         m_cnt = 0;
      end else begin
         m_e = (haz || s.flush) ? exe_t'('0) : s.d;
         if (haz && m_cnt < CNT_MAX) m_cnt++;
      end
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         item_t it;
         it = sb_q.pop_front();
         chk("sb_fwda", 32'(bus.fwda), 32'(it.fwda));
         chk("sb_fwdb", 32'(bus.fwdb), 32'(it.fwdb));
         chk("sb_wpcir", 32'(bus.wpcir), 32'(it.wpcir));
         chk("sb_ectrl", 32'({bus.ealuc, bus.ealuimm, bus.eshift, bus.em2reg,
                              bus.ewmem, bus.ewreg, bus.ern}), 32'(it.e));
         chk("sb_stall_cnt", 32'(bus.stall_cnt), 32'(it.cnt));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      s = idle();
      s.rst = 1'b1;
      s.d   = '{aluc: 3'd5, aluimm: 1'b1, shift: 1'b1, m2reg: 1'b1,
                wmem: 1'b1, wreg: 1'b1, rn: 5'd9};
      rst = 1'b1;
      bus.daluc = 3'd5; bus.daluimm = 1'b1; bus.dshift = 1'b1; bus.dm2reg = 1'b1;
      bus.dwmem = 1'b1; bus.dwreg = 1'b1; bus.drn = 5'd9; bus.drs = 5'd0;
      bus.drt = 5'd0; bus.duse_rs = 1'b0; bus.duse_rt = 1'b0; bus.flush = 1'b0;
      bus.mrn = 5'd0; bus.mwreg = 1'b0; bus.mm2reg = 1'b0;
      @(posedge clk);
      m_e   = '0;
      m_cnt = 0;
      step(s);
      chk("rst_ectrl", 32'({bus.ealuc, bus.ealuimm, bus.eshift, bus.em2reg,
                            bus.ewmem, bus.ewreg, bus.ern}), 32'd0);
      chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      chk("rst_wpcir", 32'(bus.wpcir), 32'd1);
      chk("rst_fwd", 32'({bus.fwda, bus.fwdb}), 32'd0);

      // EXE forward beats MEM forward for the same register
      s = idle(); s.d.wreg = 1'b1; s.d.rn = 5'd3;
      step(s);
      s = idle(); s.rs = 5'd3; s.use_rs = 1'b1; s.mrn = 5'd3; s.mwreg = 1'b1;
      step(s);
      chk("exe_fwd_fwda", 32'(bus.fwda), 32'd1);
      chk("exe_fwd_wpcir", 32'(bus.wpcir), 32'd1);

      // load-use: one stall, then MEM load data is selected
      s = idle(); s.d.wreg = 1'b1; s.d.m2reg = 1'b1; s.d.rn = 5'd5;
      step(s);
      s = idle(); s.rt = 5'd5; s.use_rt = 1'b1; s.d.wreg = 1'b1; s.d.rn = 5'd6;
      step(s);
      chk("lu_wpcir_stall", 32'(bus.wpcir), 32'd0);
      s.mrn = 5'd5; s.mwreg = 1'b1; s.mm2reg = 1'b1;
      step(s);
      chk("lu_bubble_ewreg", 32'(bus.ewreg), 32'd0);
      chk("lu_bubble_ern", 32'(bus.ern), 32'd0);
      chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
      chk("lu_fwdb_mmo", 32'(bus.fwdb), 32'd3);
      chk("lu_wpcir_resume", 32'(bus.wpcir), 32'd1);

      // register zero is never forwarded nor stalled on
      s = idle(); s.d.wreg = 1'b1; s.d.m2reg = 1'b1; s.d.rn = 5'd0;
      step(s);
      s = idle(); s.rs = 5'd0; s.use_rs = 1'b1; s.mwreg = 1'b1; s.mrn = 5'd0;
      step(s);
      chk("r0_fwda", 32'(bus.fwda), 32'd0);
      chk("r0_wpcir", 32'(bus.wpcir), 32'd1);

      // flush squashes a store/writeback instruction
      s = idle(); s.flush = 1'b1; s.d.wmem = 1'b1; s.d.wreg = 1'b1; s.d.rn = 5'd7;
      step(s);
      step(idle());
      chk("flush_ewmem", 32'(bus.ewmem), 32'd0);
      chk("flush_ewreg", 32'(bus.ewreg), 32'd0);
      chk("flush_ern", 32'(bus.ern), 32'd0);
      chk("flush_stall_cnt", 32'(bus.stall_cnt), 32'd1);

      for (int i = 0; i < 300; i++) step(rand_stim());

      // 20 load-use pairs drive the 4-bit counter into saturation
      for (int i = 0; i < 20; i++) begin
         s = idle(); s.d.wreg = 1'b1; s.d.m2reg = 1'b1; s.d.rn = 5'd4;
         step(s);
         s = idle(); s.rs = 5'd4; s.use_rs = 1'b1;
         step(s);
         chk("sat_wpcir", 32'(bus.wpcir), 32'd0);
      end
      step(idle());
      chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd15);

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
